// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and live occupancy count.
// Latency: write visible to status the cycle after the write edge; read data 1 cycle after accepting edge.
// Backpressure: writes dropped while full, reads dropped while empty; SYNC_FIFO_ERR_FLAGS_EN adds sticky flags.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Wr_En,
  input  logic [DATA_WIDTH-1:0]   i_Wr_Data,
  input  logic                    i_Rd_En,
  output logic [DATA_WIDTH-1:0]   o_Rd_Data,
  output logic                    o_Data_Valid,
  output logic                    o_Full,
  output logic                    o_Empty,
  output logic                    o_Almost_Full,
  output logic                    o_Almost_Empty,
  output logic [$clog2(DEPTH):0]  o_Count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                    o_Overflow,
  output logic                    o_Underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  // Storage is deliberately never reset; only pointers and count are.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_data_valid;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CW-1:0]         w_count_nxt;

  // Gating uses the registered flags, so enables may be held high blindly.
  assign w_wr_acc = i_Wr_En && !r_full;
  assign w_rd_acc = i_Rd_En && !r_empty;

  assign w_count_nxt = (w_wr_acc && !w_rd_acc) ? r_count + CW'(1) :
                       (!w_wr_acc && w_rd_acc) ? r_count - CW'(1) :
                                                 r_count;

  // Memory write port; suppressed during reset so a reset cycle leaves no trace.
  always_ff @(posedge i_Clk) begin
    if (w_wr_acc && !i_Reset) begin
      r_mem[r_wr_ptr] <= i_Wr_Data;
    end
  end

  // Pointers, read data register and status flags derived from the next-state count.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_rd_data      <= '0;
      r_data_valid   <= 1'b0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      r_data_valid   <= w_rd_acc;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == C_DEPTH);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= C_AF);
      r_almost_empty <= (w_count_nxt <= C_AE);
    end
  end

  assign o_Rd_Data      = r_rd_data;
  assign o_Data_Valid   = r_data_valid;
  assign o_Full         = r_full;
  assign o_Empty        = r_empty;
  assign o_Almost_Full  = r_almost_full;
  assign o_Almost_Empty = r_almost_empty;
  assign o_Count        = r_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags: set on any request made against the full/empty state, cleared only by reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_Wr_En && r_full) begin
        r_overflow <= 1'b1;
      end
      if (i_Rd_En && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_Overflow  = r_overflow;
  assign o_Underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: directed steps plus random traffic against a queue-based reference.
// Every cycle compares all outputs with the reference taken from the behavioural rules.
// Error-flag checks are compiled in only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          i_Clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Wr_En = 1'b0;
  logic [DW-1:0] i_Wr_Data = '0;
  logic          i_Rd_En = 1'b0;
  logic [DW-1:0] o_Rd_Data;
  logic          o_Data_Valid;
  logic          o_Full;
  logic          o_Empty;
  logic          o_Almost_Full;
  logic          o_Almost_Empty;
  logic [4:0]    o_Count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          o_Overflow;
  logic          o_Underflow;
`endif

  sync_fifo_prog #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Wr_En        (i_Wr_En),
    .i_Wr_Data      (i_Wr_Data),
    .i_Rd_En        (i_Rd_En),
    .o_Rd_Data      (o_Rd_Data),
    .o_Data_Valid   (o_Data_Valid),
    .o_Full         (o_Full),
    .o_Empty        (o_Empty),
    .o_Almost_Full  (o_Almost_Full),
    .o_Almost_Empty (o_Almost_Empty),
    .o_Count        (o_Count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .o_Overflow     (o_Overflow),
    .o_Underflow    (o_Underflow)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: contents as a queue, plus expected read-side outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data  = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ovf   = 1'b0;
  logic          exp_unf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count",        32'(o_Count),        32'(sz));
    chk("empty",        32'(o_Empty),        32'(sz == 0));
    chk("full",         32'(o_Full),         32'(sz == DEPTH));
    chk("almost_full",  32'(o_Almost_Full),  32'(sz >= AF));
    chk("almost_empty", 32'(o_Almost_Empty), 32'(sz <= AE));
    chk("data_valid",   32'(o_Data_Valid),   32'(exp_valid));
    chk("rd_data",      32'(o_Rd_Data),      32'(exp_data));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow",     32'(o_Overflow),     32'(exp_ovf));
    chk("underflow",    32'(o_Underflow),    32'(exp_unf));
`endif
  endtask

  // One clock cycle: drive, advance the reference across the edge, then compare.
  task automatic step(input logic rst, input logic wr, input logic [DW-1:0] d, input logic rd);
    int sz;
    i_Reset   = rst;
    i_Wr_En   = wr;
    i_Wr_Data = d;
    i_Rd_En   = rd;
    @(posedge i_Clk);
    sz = q.size();
    if (rst) begin
      q.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      if (wr && sz == DEPTH) exp_ovf = 1'b1;
      if (rd && sz == 0)     exp_unf = 1'b1;
      exp_valid = rd && (sz > 0);
      if (exp_valid) exp_data = q.pop_front();
      if (wr && sz < DEPTH) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset held for two cycles.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // Fill with 0x00..0x0F; thresholds are checked at every count on the way.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
    chk("full_after_fill", 32'(o_Full), 32'd1);
    // Write while full is dropped.
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    // Full with write+read: only the read is accepted.
    step(1'b0, 1'b1, 8'hDD, 1'b1);
    chk("full_wr_rd_count", 32'(o_Count), 32'd15);
    step(1'b0, 1'b1, 8'h10, 1'b0);

    // Drain; the last word arrives together with o_Empty.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("empty_on_last", 32'({o_Empty, o_Data_Valid}), 32'b11);
    // Read while empty is dropped and data holds.
    step(1'b0, 1'b0, '0, 1'b1);
    // Empty with write+read: only the write is accepted.
    step(1'b0, 1'b1, 8'h42, 1'b1);
    chk("empty_wr_rd_valid", 32'(o_Data_Valid), 32'd0);

    // Bring count to 5, then 20 cycles of simultaneous write+read across the pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, DW'($urandom), 1'b1);
      chk("steady_count5", 32'(o_Count), 32'd5);
    end

    // Random traffic in three phases biased toward fill, balance, drain.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 150; i++) begin
        logic w, r;
        w = ($urandom_range(0, 9) < (p == 0 ? 8 : (p == 1 ? 5 : 2)));
        r = ($urandom_range(0, 9) < (p == 0 ? 2 : (p == 1 ? 5 : 8)));
        step(1'b0, w, DW'($urandom), r);
      end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Force both error conditions and confirm they stick.
    while (q.size() > 0) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("underflow_set", 32'(o_Underflow), 32'd1);
    while (q.size() < DEPTH) step(1'b0, 1'b1, DW'($urandom), 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0);
    chk("overflow_set", 32'(o_Overflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("overflow_sticky", 32'(o_Overflow), 32'd1);
`endif

    // Mid-operation reset at count 7 with both enables high: reset wins.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0);
    chk("count7", 32'(o_Count), 32'd7);
    step(1'b1, 1'b1, 8'hAA, 1'b1);
    chk("reset_count", 32'(o_Count), 32'd0);
    chk("reset_valid", 32'(o_Data_Valid), 32'd0);
    step(1'b0, 1'b1, 8'h5C, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("post_reset_word", 32'(o_Rd_Data), 32'h5C);
    step(1'b0, 1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
